reg_cmd_fsm: RTL and testbench
==============================

Name: reg_cmd_fsm

Overview:
Parametrised byte-stream command decoder between the UART RX/TX byte interfaces and the register file.
- Frame format: command byte, then ADDR_W/8 address bytes, then for writes DATA_W/8 data bytes. All fields MSB first.
- Writes issue a single-cycle write strobe.
- Reads issue a read strobe, capture the returned word and serialise it back over the TX byte interface.
- Adds multi-byte fields, read-back, an inter-byte timeout and error reporting.

Parameters:
- ADDR_W, 8, register address width in bits; multiple of 8, range 8..32.
- DATA_W, 8, register data width in bits; multiple of 8, range 8..32.
- TIMEOUT_CYC, 100000, maximum idle cycles allowed mid-frame or while waiting for read data; 0 disables the timeout.
- CMD_WR, 8'h01, write command code.
- CMD_RD, 8'h02, read command code.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-high
- rx_valid_i  in  1  one-cycle pulse: rx_data_i holds a received byte
- rx_data_i  in  8  received byte
- tx_ready_i  in  1  TX serializer can accept a byte
- tx_valid_o  out  1  tx_data_o is valid
- tx_data_o  out  8  byte to transmit
- reg_addr_o  out  ADDR_W  register address
- reg_wdata_o  out  DATA_W  register write data
- reg_wr_o  out  1  one-cycle write strobe
- reg_rd_o  out  1  one-cycle read strobe
- reg_rdata_i  in  DATA_W  read data
- reg_rvalid_i  in  1  reg_rdata_i valid (pulse, at least 1 cycle after reg_rd_o)
- busy_o  out  1  high whenever state is not S_CMD
- err_o  out  1  one-cycle error pulse

Behaviour:
- Reset (rst_n=1, asynchronous):
  - state = S_CMD.
  - All outputs 0; address, data, capture registers, byte counter and timeout counter cleared.
  - A frame in progress is abandoned; no strobe is emitted.
- States: S_CMD, S_ADDR, S_WDATA, S_RWAIT, S_TX.
- S_CMD, on rx_valid_i:
  - byte == CMD_WR or CMD_RD: latch the command, clear the byte counter, go to S_ADDR.
  - byte == 8'h00 (NOP): remain in S_CMD, no error.
  - any other byte: err_o pulses the next cycle, remain in S_CMD.
- S_ADDR:
  - Each rx_valid_i shifts the byte into the address shift register (addr = {addr[ADDR_W-9:0], byte}).
  - On the ADDR_W/8-th byte:
    - WR: go to S_WDATA.
    - RD: reg_addr_o updates and reg_rd_o pulses, both in the cycle after the byte; go to S_RWAIT.
- S_WDATA:
  - Bytes shift into the data register the same way.
  - On the DATA_W/8-th byte, in the next cycle: reg_addr_o and reg_wdata_o update and reg_wr_o pulses for exactly 1 cycle. Return to S_CMD.
- reg_addr_o and reg_wdata_o hold their values between strobes. Partially assembled fields are never visible on these outputs.
- S_RWAIT:
  - On reg_rvalid_i: capture reg_rdata_i, set the TX byte index to 0, go to S_TX.
- S_TX:
  - tx_valid_o = 1 and tx_data_o = the captured byte at the current index, MSB first.
  - A byte transfers on a cycle with tx_valid_o and tx_ready_i both high; the index then advances.
  - tx_data_o is stable while tx_valid_o=1 and tx_ready_i=0.
  - After the DATA_W/8-th transfer, tx_valid_o drops in the next cycle and the state returns to S_CMD.
- rx_valid_i in S_RWAIT or S_TX: byte dropped, err_o pulses, the response continues unaffected.
- Timeout:
  - The counter resets on every accepted rx byte and on entry to S_RWAIT. It counts in S_ADDR, S_WDATA and S_RWAIT.
  - Reaching TIMEOUT_CYC: err_o pulses, go to S_CMD, no strobe.
  - If rvalid is lost, no TX bytes are sent.
  - The counter is held at 0 in S_CMD and S_TX.
- Simultaneous events: reg_rvalid_i in the same cycle as timeout expiry counts as data arriving; no error.
- err_o pulses: at most one per cycle; each event gives exactly one 1-cycle pulse.

Test Plan:
- Write, ADDR_W=16, DATA_W=32: RX 01,12,34,DE,AD,BE,EF -> 1 cycle after the last byte, reg_wr_o=1 for 1 cycle with reg_addr_o=16'h1234 and reg_wdata_o=32'hDEADBEEF; busy_o=0 afterwards.
- Read with back-pressure, ADDR_W=16, DATA_W=32: RX 02,00,10; rdata=32'hCAFEF00D 3 cycles after reg_rd_o; tx_ready_i toggles 1-0-1 -> reg_rd_o pulse with addr 16'h0010; TX bytes CA,FE,F0,0D in order; tx_data_o stable while stalled.
- Bad/NOP command (defaults): RX 00 -> no err, still idle; RX 7F -> err_o 1-cycle pulse; then RX 01,05,AA -> reg_wr_o with addr 8'h05, data 8'hAA.
- Timeout, TIMEOUT_CYC=20: RX 01,12 then silence -> err_o pulse 20 cycles after the last byte, state back to S_CMD; a following full frame works.
- Read timeout and RX during TX:
  - RX 02,33 with no reg_rvalid_i -> err_o after TIMEOUT_CYC, no tx_valid_o.
  - Separately, an RX byte during S_TX -> err_o pulse, response bytes still correct.
- Reset mid-frame: assert rst_n after RX 01,05 -> all outputs 0 immediately (async); after release, RX AA alone produces no reg_wr_o (treated as a bad command, err_o).

Source files
------------

// File: rtl/reg_cmd_fsm.sv
// Byte-stream command decoder: CMD byte, ADDR_W/8 address bytes, DATA_W/8 data bytes (writes), all MSB first.
// Writes raise a one-cycle register strobe; reads return the word over TX; stalls mid-frame time out via err_o.
module reg_cmd_fsm #(
  parameter int          ADDR_W      = 8,
  parameter int          DATA_W      = 8,
  parameter int          TIMEOUT_CYC = 100000,
  parameter logic [7:0]  CMD_WR      = 8'h01,
  parameter logic [7:0]  CMD_RD      = 8'h02
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  input  logic              tx_ready_i,
  output logic              tx_valid_o,
  output logic [7:0]        tx_data_o,
  output logic [ADDR_W-1:0] reg_addr_o,
  output logic [DATA_W-1:0] reg_wdata_o,
  output logic              reg_wr_o,
  output logic              reg_rd_o,
  input  logic [DATA_W-1:0] reg_rdata_i,
  input  logic              reg_rvalid_i,
  output logic              busy_o,
  output logic              err_o
);

  localparam logic [2:0] ADDR_LAST = 3'(ADDR_W / 8 - 1);
  localparam logic [2:0] DATA_LAST = 3'(DATA_W / 8 - 1);
  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam bit TO_EN = (TIMEOUT_CYC > 0);

  typedef enum logic [2:0] {S_CMD, S_ADDR, S_WDATA, S_RWAIT, S_TX} state_t;

  state_t            state_q, state_d;
  logic              is_rd_q;
  logic [ADDR_W-1:0] addr_sh_q;
  logic [DATA_W-1:0] data_sh_q;
  logic [DATA_W-1:0] tx_buf_q;
  logic [2:0]        cnt_q;
  logic [TO_W-1:0]   to_q;

  logic [ADDR_W-1:0] addr_nx;
  logic [DATA_W-1:0] data_nx;
  logic              to_hit;
  logic              latch_cmd, shift_addr, shift_data, fire_wr, fire_rd;
  logic              capture, tx_adv, err_d, to_clr, to_inc, cnt_clr, cnt_inc;

  assign addr_nx = (addr_sh_q << 8) | ADDR_W'(rx_data_i);
  assign data_nx = (data_sh_q << 8) | DATA_W'(rx_data_i);
  assign to_hit  = TO_EN && (to_q == TO_LAST);

  assign busy_o     = (state_q != S_CMD);
  assign tx_valid_o = (state_q == S_TX);
  assign tx_data_o  = tx_valid_o ? tx_buf_q[DATA_W-1 -: 8] : 8'h00;

  always_comb begin
    state_d    = state_q;
    latch_cmd  = 1'b0;
    shift_addr = 1'b0;
    shift_data = 1'b0;
    fire_wr    = 1'b0;
    fire_rd    = 1'b0;
    capture    = 1'b0;
    tx_adv     = 1'b0;
    err_d      = 1'b0;
    to_clr     = 1'b0;
    to_inc     = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    case (state_q)
      S_CMD: begin
        if (rx_valid_i) begin
          if (rx_data_i == CMD_WR || rx_data_i == CMD_RD) begin
            latch_cmd = 1'b1;
            cnt_clr   = 1'b1;
            state_d   = S_ADDR;
          end else if (rx_data_i != 8'h00) begin
            err_d = 1'b1;
          end
        end
      end
      S_ADDR: begin
        if (rx_valid_i) begin
          shift_addr = 1'b1;
          to_clr     = 1'b1;
          if (cnt_q == ADDR_LAST) begin
            cnt_clr = 1'b1;
            if (is_rd_q) begin
              fire_rd = 1'b1;
              state_d = S_RWAIT;
            end else begin
              state_d = S_WDATA;
            end
          end else begin
            cnt_inc = 1'b1;
          end
        end else if (to_hit) begin
          err_d   = 1'b1;
          state_d = S_CMD;
        end else begin
          to_inc = 1'b1;
        end
      end
      S_WDATA: begin
        if (rx_valid_i) begin
          shift_data = 1'b1;
          to_clr     = 1'b1;
          if (cnt_q == DATA_LAST) begin
            cnt_clr = 1'b1;
            fire_wr = 1'b1;
            state_d = S_CMD;
          end else begin
            cnt_inc = 1'b1;
          end
        end else if (to_hit) begin
          err_d   = 1'b1;
          state_d = S_CMD;
        end else begin
          to_inc = 1'b1;
        end
      end
      S_RWAIT: begin
        err_d = rx_valid_i;
        // Data arriving on the expiry cycle wins over the timeout.
        if (reg_rvalid_i) begin
          capture = 1'b1;
          cnt_clr = 1'b1;
          state_d = S_TX;
        end else if (to_hit) begin
          err_d   = 1'b1;
          state_d = S_CMD;
        end else begin
          to_inc = 1'b1;
        end
      end
      S_TX: begin
        err_d = rx_valid_i;
        if (tx_ready_i) begin
          tx_adv  = 1'b1;
          cnt_inc = 1'b1;
          if (cnt_q == DATA_LAST) state_d = S_CMD;
        end
      end
      default: state_d = S_CMD;
    endcase
    if (state_d == S_CMD || state_d == S_TX) to_clr = 1'b1;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state_q <= S_CMD;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      is_rd_q     <= 1'b0;
      addr_sh_q   <= '0;
      data_sh_q   <= '0;
      tx_buf_q    <= '0;
      cnt_q       <= '0;
      to_q        <= '0;
      reg_addr_o  <= '0;
      reg_wdata_o <= '0;
      reg_wr_o    <= 1'b0;
      reg_rd_o    <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      err_o    <= err_d;
      reg_wr_o <= fire_wr;
      reg_rd_o <= fire_rd;
      if (latch_cmd)  is_rd_q   <= (rx_data_i == CMD_RD);
      if (shift_addr) addr_sh_q <= addr_nx;
      if (shift_data) data_sh_q <= data_nx;
      // Outputs only change with a strobe, so partial fields never leak out.
      if (fire_rd) reg_addr_o <= addr_nx;
      if (fire_wr) begin
        reg_addr_o  <= addr_sh_q;
        reg_wdata_o <= data_nx;
      end
      if (cnt_clr)      cnt_q <= '0;
      else if (cnt_inc) cnt_q <= cnt_q + 3'd1;
      if (to_clr)      to_q <= '0;
      else if (to_inc) to_q <= to_q + TO_W'(1);
      if (capture)     tx_buf_q <= reg_rdata_i;
      else if (tx_adv) tx_buf_q <= tx_buf_q << 8;
    end
  end

endmodule

// File: tb/tb_reg_cmd_fsm.sv
// Bench for reg_cmd_fsm (ADDR_W=16, DATA_W=32, TIMEOUT_CYC=20): directed frame table, timing corners,
// and random frames whose expected strobes/TX/errors come from a frame-level model.
module tb_reg_cmd_fsm;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TO = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          rx_valid_i = 1'b0;
  logic [7:0]    rx_data_i = '0;
  logic          tx_ready_i;
  logic          tx_valid_o;
  logic [7:0]    tx_data_o;
  logic [AW-1:0] reg_addr_o;
  logic [DW-1:0] reg_wdata_o;
  logic          reg_wr_o, reg_rd_o;
  logic [DW-1:0] reg_rdata_i;
  logic          reg_rvalid_i;
  logic          busy_o, err_o;

  reg_cmd_fsm #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i),
    .tx_ready_i(tx_ready_i), .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o),
    .reg_addr_o(reg_addr_o), .reg_wdata_o(reg_wdata_o),
    .reg_wr_o(reg_wr_o), .reg_rd_o(reg_rd_o),
    .reg_rdata_i(reg_rdata_i), .reg_rvalid_i(reg_rvalid_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Observed events, collected away from the active edge.
  logic [47:0] wr_q[$];
  logic [15:0] rd_q[$];
  logic [7:0]  tx_q[$];
  int          err_n = 0;
  int          err_cyc = 0;
  int          last_rx_cyc = 0;
  logic        stall_q = 1'b0;
  logic [7:0]  stall_dat = '0;

  always @(negedge clk) begin
    if (reg_wr_o) wr_q.push_back({reg_addr_o, reg_wdata_o});
    if (reg_rd_o) rd_q.push_back(reg_addr_o);
    if (tx_valid_o && tx_ready_i) tx_q.push_back(tx_data_o);
    if (err_o) begin
      err_n++;
      err_cyc = cyc;
    end
    if (stall_q) chk("tx_hold", {55'd0, tx_valid_o, tx_data_o}, {55'd0, 1'b1, stall_dat});
    stall_q   = tx_valid_o && !tx_ready_i;
    stall_dat = tx_data_o;
  end

  // Register-file stub: answers each read strobe after resp_dly cycles with rd_word.
  logic        resp_en = 1'b1;
  int          resp_dly = 2;
  logic [31:0] rd_word = '0;
  initial begin : responder
    reg_rvalid_i = 1'b0;
    reg_rdata_i  = '0;
    forever begin
      @(negedge clk);
      if (reg_rd_o && resp_en) begin
        repeat (resp_dly) @(posedge clk);
        #1 reg_rvalid_i = 1'b1; reg_rdata_i = rd_word;
        @(posedge clk);
        #1 reg_rvalid_i = 1'b0; reg_rdata_i = '0;
      end
    end
  end

  // TX sink: 0 = always ready, 1 = random, 2 = alternating.
  int tx_mode = 0;
  initial begin : tx_sink
    tx_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (tx_mode)
        0:       tx_ready_i = 1'b1;
        1:       tx_ready_i = 1'($urandom_range(0, 1));
        default: tx_ready_i = ~tx_ready_i;
      endcase
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  // Bytes are left-aligned in fr; consecutive bytes are sampled g cycles apart.
  task automatic send_frame(input logic [63:0] fr, input int n, input int g);
    for (int i = 0; i < n; i++) begin
      rx_valid_i = 1'b1;
      rx_data_i  = fr[63-8*i -: 8];
      @(posedge clk);
      #1;
      last_rx_cyc = cyc;
      rx_valid_i = 1'b0;
      rx_data_i  = '0;
      if (i < n - 1) repeat (g - 1) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("idle_reached", {63'd0, busy_o}, 64'd0);
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic clear_obs();
    wr_q.delete();
    rd_q.delete();
    tx_q.delete();
    err_n = 0;
  endtask

  typedef struct {
    logic [63:0] fr;
    int          n;
    int          g;
    int          dly;
    logic [31:0] rdw;
    int          e_wr;
    logic [15:0] e_addr;
    logic [31:0] e_data;
    int          e_rd;
    int          e_tx;
    int          e_err;
  } vec_t;

  task automatic run_vec(input vec_t v, input string tag);
    clear_obs();
    resp_dly = v.dly;
    rd_word  = v.rdw;
    send_frame(v.fr, v.n, v.g);
    wait_idle();
    chk({tag, "_wr_cnt"}, 64'(wr_q.size()), 64'(v.e_wr));
    if (v.e_wr == 1 && wr_q.size() == 1) chk({tag, "_wr_addr_data"}, 64'(wr_q[0]), {16'd0, v.e_addr, v.e_data});
    chk({tag, "_rd_cnt"}, 64'(rd_q.size()), 64'(v.e_rd));
    if (v.e_rd == 1 && rd_q.size() == 1) chk({tag, "_rd_addr"}, 64'(rd_q[0]), 64'(v.e_addr));
    chk({tag, "_tx_cnt"}, 64'(tx_q.size()), 64'(4 * v.e_tx));
    if (v.e_tx == 1 && tx_q.size() == 4) chk({tag, "_tx_word"}, {32'd0, tx_q[0], tx_q[1], tx_q[2], tx_q[3]}, 64'(v.e_data));
    chk({tag, "_err_cnt"}, 64'(err_n), 64'(v.e_err));
  endtask

  vec_t        vt [12];
  vec_t        rv;
  int          ty;
  logic [15:0] ra;
  logic [31:0] rdat;
  logic [7:0]  cmd;

  initial begin : main
    //           fr                      n  g   dly rdw           wr addr      data          rd tx err
    vt[0]  = '{64'h0112_34DE_ADBE_EF00, 7, 1,  2,  32'h0,        1, 16'h1234, 32'hDEADBEEF, 0, 0, 0};
    vt[1]  = '{64'h0200_1000_0000_0000, 3, 2,  2,  32'hCAFEF00D, 0, 16'h0010, 32'hCAFEF00D, 1, 1, 0};
    vt[2]  = '{64'h0000_0000_0000_0000, 1, 1,  2,  32'h0,        0, 16'h0000, 32'h0,        0, 0, 0};
    vt[3]  = '{64'h7F00_0000_0000_0000, 1, 1,  2,  32'h0,        0, 16'h0000, 32'h0,        0, 0, 1};
    vt[4]  = '{64'h0100_0500_0000_AA00, 7, 3,  2,  32'h0,        1, 16'h0005, 32'h000000AA, 0, 0, 0};
    vt[5]  = '{64'h01AB_CD12_3456_7800, 7, 20, 2,  32'h0,        1, 16'hABCD, 32'h12345678, 0, 0, 0};
    vt[6]  = '{64'h0100_0500_0000_0000, 3, 21, 2,  32'h0,        0, 16'h0000, 32'h0,        0, 0, 2};
    vt[7]  = '{64'h0112_0000_0000_0000, 2, 1,  2,  32'h0,        0, 16'h0000, 32'h0,        0, 0, 1};
    vt[8]  = '{64'h0242_4200_0000_0000, 3, 1,  19, 32'h0BADF00D, 0, 16'h4242, 32'h0BADF00D, 1, 1, 0};
    vt[9]  = '{64'h0242_4300_0000_0000, 3, 1,  20, 32'h0BADF00D, 0, 16'h4243, 32'h0,        1, 0, 1};
    vt[10] = '{64'h01FF_FFFF_FFFF_FF00, 7, 1,  2,  32'h0,        1, 16'hFFFF, 32'hFFFFFFFF, 0, 0, 0};
    vt[11] = '{64'h0200_0000_0000_0000, 3, 1,  1,  32'h80000001, 0, 16'h0000, 32'h80000001, 1, 1, 0};

    repeat (3) begin @(posedge clk); #1; end
    chk("reset_outputs", {3'd0, tx_valid_o, tx_data_o, reg_addr_o, reg_wdata_o, reg_wr_o, reg_rd_o, busy_o, err_o}, 64'd0);
    rst_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    tx_mode = 2;
    for (int i = 0; i < 12; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Timeout lands exactly TO cycles after the last accepted byte (write) or the read strobe.
    clear_obs();
    send_frame(64'h0112_0000_0000_0000, 2, 1);
    wait_idle();
    chk("wr_timeout_err", 64'(err_n), 64'd1);
    chk("wr_timeout_delay", 64'(err_cyc - last_rx_cyc), 64'(TO));
    clear_obs();
    resp_en = 1'b0;
    send_frame(64'h0200_3300_0000_0000, 3, 1);
    wait_idle();
    resp_en = 1'b1;
    chk("rd_timeout_err", 64'(err_n), 64'd1);
    chk("rd_timeout_delay", 64'(err_cyc - last_rx_cyc), 64'(TO));
    chk("rd_timeout_no_tx", 64'(tx_q.size()), 64'd0);

    // A byte arriving during the response is dropped with an error; the response completes.
    clear_obs();
    rd_word  = 32'h1357_9BDF;
    resp_dly = 2;
    send_frame(64'h0200_AB00_0000_0000, 3, 1);
    for (int n = 0; n < 50 && !tx_valid_o; n++) begin @(posedge clk); #1; end
    chk("tx_started", {63'd0, tx_valid_o}, 64'd1);
    send_frame(64'h0100_0000_0000_0000, 1, 1);
    wait_idle();
    chk("rx_in_tx_err", 64'(err_n), 64'd1);
    chk("rx_in_tx_cnt", 64'(tx_q.size()), 64'd4);
    if (tx_q.size() == 4) chk("rx_in_tx_word", {32'd0, tx_q[0], tx_q[1], tx_q[2], tx_q[3]}, 64'h1357_9BDF);
    chk("rx_in_tx_no_wr", 64'(wr_q.size()), 64'd0);

    // Asynchronous reset in the middle of a write frame.
    clear_obs();
    send_frame(64'h0100_0500_0000_0000, 3, 1);
    chk("pre_reset_busy", {63'd0, busy_o}, 64'd1);
    #2 rst_n = 1'b1;
    #1 chk("async_reset_outputs", {3'd0, tx_valid_o, tx_data_o, reg_addr_o, reg_wdata_o, reg_wr_o, reg_rd_o, busy_o, err_o}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    send_frame(64'hAA00_0000_0000_0000, 1, 1);
    wait_idle();
    chk("post_reset_err", 64'(err_n), 64'd1);
    chk("post_reset_no_wr", 64'(wr_q.size()), 64'd0);

    // Random frames: expectations derived from frame type alone.
    tx_mode = 1;
    for (int k = 0; k < 40; k++) begin
      ty   = $urandom_range(0, 4);
      ra   = 16'($urandom);
      rdat = $urandom;
      rv   = '{64'd0, 1, 1, 2, 32'd0, 0, 16'd0, 32'd0, 0, 0, 0};
      rv.g   = $urandom_range(1, TO);
      rv.dly = $urandom_range(1, TO - 1);
      case (ty)
        0: rv.fr = 64'd0;
        1: begin
          cmd      = 8'($urandom_range(3, 255));
          rv.fr    = {cmd, 56'd0};
          rv.e_err = 1;
        end
        2: begin
          rv.fr = {8'h01, ra, rdat, 8'h00};
          rv.n = 7; rv.e_wr = 1; rv.e_addr = ra; rv.e_data = rdat;
        end
        3: begin
          rv.fr = {8'h02, ra, 40'd0};
          rv.n = 3; rv.rdw = rdat; rv.e_rd = 1; rv.e_tx = 1; rv.e_addr = ra; rv.e_data = rdat;
        end
        default: begin
          cmd      = ($urandom_range(0, 1) == 0) ? 8'h01 : 8'h02;
          rv.fr    = {cmd, ra, rdat, 8'h00};
          rv.n     = (cmd == 8'h01) ? $urandom_range(1, 6) : $urandom_range(1, 2);
          rv.e_err = 1;
        end
      endcase
      run_vec(rv, $sformatf("rnd%0d_t%0d", k, ty));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
